led_mode_ctrl: RTL and testbench

Mode controller for the LED PWM datapath. It accepts mode commands (OFF / ON / BLINK / BREATH) over a valid/ready handshake and produces the duty-cycle threshold consumed by the PWM comparator. Duty changes are applied only at PWM period boundaries, signalled by the PWM counter, so the LED output never glitches mid-period. It sits between the system control logic and the PWM counter/comparator slice.

---
 rtl/led_mode_if.sv | 24 ++
 rtl/led_mode_ctrl.sv | 135 +++++++++++++
 tb/tb_led_mode_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_mode_if.sv
// Command and PWM-boundary bundle between system control, the mode controller
// and the PWM counter/comparator slice.
interface led_mode_if #(
    parameter int DW = 16
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_mode;
    logic [7:0]    cmd_step;
    logic          period_end;
    logic [DW-1:0] duty;
    logic [1:0]    mode;
    logic          breath_done;

    modport master (
        output cmd_valid, cmd_mode, cmd_step, period_end,
        input  cmd_ready, duty, mode, breath_done
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_step, period_end,
        output cmd_ready, duty, mode, breath_done
    );
endinterface

// File: rtl/led_mode_ctrl.sv
// LED mode controller: accepts OFF/ON/BLINK/BREATH commands and updates the PWM
// duty threshold only on PWM period boundaries so the output never glitches.
module led_mode_ctrl #(
    parameter int DW            = 16,
    parameter int PWM_MAX       = 100,
    parameter int BLINK_PERIODS = 50
) (
    input  logic     clk,
    input  logic     rst,
    led_mode_if.slave bus
);
    localparam int            CW       = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [DW-1:0] DUTY_MAX = DW'(PWM_MAX);
    localparam logic [DW:0]   SUM_MAX  = (DW+1)'(PWM_MAX);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLINK_PERIODS - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_ON,
        S_BLK_H,
        S_BLK_L,
        S_BR_UP,
        S_BR_DN
    } state_t;

    state_t        state_reg;
    logic [DW-1:0] duty_reg;
    logic [1:0]    mode_reg;
    logic          breath_done_reg;
    logic          cmd_ready_reg;
    logic [1:0]    pend_mode_reg;
    logic [7:0]    pend_step_reg;
    logic [7:0]    step_reg;
    logic [CW-1:0] blk_cnt_reg;

    // Breath arithmetic is done one bit wider so the ramp cannot wrap.
    logic [DW:0] step_ext;
    logic [DW:0] sum;

    assign step_ext = (DW+1)'(step_reg);
    assign sum      = {1'b0, duty_reg} + step_ext;

    // cmd_ready low doubles as the "command pending" flag: one slot, no queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_OFF;
            duty_reg        <= '0;
            mode_reg        <= 2'd0;
            breath_done_reg <= 1'b0;
            cmd_ready_reg   <= 1'b1;
            pend_mode_reg   <= 2'd0;
            pend_step_reg   <= 8'd0;
            step_reg        <= 8'd1;
            blk_cnt_reg     <= '0;
        end else begin
            breath_done_reg <= 1'b0;

            if (bus.cmd_valid && cmd_ready_reg) begin
                pend_mode_reg <= bus.cmd_mode;
                pend_step_reg <= bus.cmd_step;
                cmd_ready_reg <= 1'b0;
            end

            if (bus.period_end) begin
                if (!cmd_ready_reg) begin
                    // A pending command overrides the mode's own boundary update.
                    cmd_ready_reg <= 1'b1;
                    mode_reg      <= pend_mode_reg;
                    blk_cnt_reg   <= '0;
                    case (pend_mode_reg)
                        2'd0: begin
                            state_reg <= S_OFF;
                            duty_reg  <= '0;
                        end
                        2'd1: begin
                            state_reg <= S_ON;
                            duty_reg  <= DUTY_MAX;
                        end
                        2'd2: begin
                            state_reg <= S_BLK_H;
                            duty_reg  <= DUTY_MAX;
                        end
                        default: begin
                            state_reg <= S_BR_UP;
                            duty_reg  <= '0;
                            step_reg  <= (pend_step_reg == 8'd0) ? 8'd1 : pend_step_reg;
                        end
                    endcase
                end else begin
                    case (state_reg)
                        S_BLK_H, S_BLK_L: begin
                            if (blk_cnt_reg == BLK_LAST) begin
                                blk_cnt_reg <= '0;
                                if (state_reg == S_BLK_H) begin
                                    state_reg <= S_BLK_L;
                                    duty_reg  <= '0;
                                end else begin
                                    state_reg <= S_BLK_H;
                                    duty_reg  <= DUTY_MAX;
                                end
                            end else begin
                                blk_cnt_reg <= blk_cnt_reg + CW'(1);
                            end
                        end
                        S_BR_UP: begin
                            if (sum >= SUM_MAX) begin
                                duty_reg  <= DUTY_MAX;
                                state_reg <= S_BR_DN;
                            end else begin
                                duty_reg <= sum[DW-1:0];
                            end
                        end
                        S_BR_DN: begin
                            if ({1'b0, duty_reg} <= step_ext) begin
                                duty_reg        <= '0;
                                state_reg       <= S_BR_UP;
                                breath_done_reg <= 1'b1;
                            end else begin
                                duty_reg <= duty_reg - step_ext[DW-1:0];
                            end
                        end
                        default: begin
                            state_reg <= state_reg;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_reg;
    assign bus.duty        = duty_reg;
    assign bus.mode        = mode_reg;
    assign bus.breath_done = breath_done_reg;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl: expected duty/mode/breath_done values are
// queued with each stimulus and popped after the period boundary that should produce them.
module tb_led_mode_ctrl;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    led_mode_if #(.DW(DW)) bus ();

    led_mode_ctrl #(
        .DW            (DW),
        .PWM_MAX       (100),
        .BLINK_PERIODS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] duty;
        logic [1:0]    mode;
        logic          bd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   bd_cnt  = 0;

    always @(posedge clk) begin
        if (bus.breath_done === 1'b1) bd_cnt <= bd_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int m, input bit b);
        exp_t e;
        e.duty = DW'(d);
        e.mode = 2'(m);
        e.bd   = b;
        exp_q.push_back(e);
    endtask

    // One PWM period: gap-1 idle cycles, then a single period_end pulse.
    task automatic pe(input int gap);
        bus.period_end = 1'b0;
        repeat (gap - 1) tick();
        bus.period_end = 1'b1;
        tick();
        bus.period_end = 1'b0;
    endtask

    task automatic send(input logic [1:0] m, input logic [7:0] s);
        int w;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 300) begin
            tick();
            w++;
        end
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_wait: cmd_ready=%b required 1 within 300 cycles", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = m;
        bus.cmd_step  = s;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_tests++; if (bus.duty !== 16'd0) begin n_fail++; $display("FAIL reset_duty: got %0d want 0", bus.duty); end
        n_tests++; if (bus.mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", bus.mode); end
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
        n_tests++; if (bus.breath_done !== 1'b0) begin n_fail++; $display("FAIL reset_bdone: got %b want 0", bus.breath_done); end
    endtask

    task automatic test_on();
        exp_t e;
        repeat (4) tick();
        send(2'd1, 8'd0);
        n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL on_ready_drop: got %b want 0", bus.cmd_ready); end
        n_tests++; if (bus.duty !== 16'd0) begin n_fail++; $display("FAIL on_duty_hold: got %0d want 0", bus.duty); end
        push(100, 1, 1'b0);
        pe(7);
        e = exp_q.pop_front();
        n_tests++; if (bus.duty !== e.duty) begin n_fail++; $display("FAIL on_duty: got %0d want %0d", bus.duty, e.duty); end
        n_tests++; if (bus.mode !== e.mode) begin n_fail++; $display("FAIL on_mode: got %0d want %0d", bus.mode, e.mode); end
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL on_ready_back: got %b want 1", bus.cmd_ready); end
        $display("[TB] on: duty=%0d mode=%0d", bus.duty, bus.mode);
    endtask

    task automatic test_breath();
        exp_t e;
        int   d[10] = '{0, 30, 60, 90, 100, 70, 40, 10, 0, 30};
        int   bd0;
        send(2'd3, 8'd30);
        for (int i = 0; i < 10; i++) push(d[i], 3, i == 8);
        bd0 = bd_cnt;
        for (int i = 0; i < 10; i++) begin
            pe(101);
            e = exp_q.pop_front();
            n_tests++; if (bus.duty !== e.duty) begin n_fail++; $display("FAIL breath_duty[%0d]: got %0d want %0d", i, bus.duty, e.duty); end
            n_tests++; if (bus.breath_done !== e.bd) begin n_fail++; $display("FAIL breath_bdone[%0d]: got %b want %b", i, bus.breath_done, e.bd); end
            $display("[TB] breath period %0d: duty=%0d bd=%b", i, bus.duty, bus.breath_done);
        end
        n_tests++; if (bus.mode !== 2'd3) begin n_fail++; $display("FAIL breath_mode: got %0d want 3", bus.mode); end
        repeat (2) tick();
        n_tests++; if (bd_cnt - bd0 !== 1) begin n_fail++; $display("FAIL breath_done_count: got %0d want 1", bd_cnt - bd0); end
    endtask

    task automatic test_step_zero();
        exp_t e;
        send(2'd3, 8'd0);
        for (int i = 0; i < 5; i++) push(i, 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            pe(4);
            e = exp_q.pop_front();
            n_tests++; if (bus.duty !== e.duty) begin n_fail++; $display("FAIL step0_duty[%0d]: got %0d want %0d", i, bus.duty, e.duty); end
            $display("[TB] step0 period %0d: duty=%0d", i, bus.duty);
        end
    endtask

    task automatic test_blink();
        exp_t e;
        int   d[8] = '{100, 100, 100, 0, 0, 0, 100, 100};
        send(2'd2, 8'd0);
        for (int i = 0; i < 8; i++) push(d[i], 2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pe(5);
            e = exp_q.pop_front();
            n_tests++; if (bus.duty !== e.duty) begin n_fail++; $display("FAIL blink_duty[%0d]: got %0d want %0d", i, bus.duty, e.duty); end
            n_tests++; if (bus.mode !== e.mode) begin n_fail++; $display("FAIL blink_mode[%0d]: got %0d want %0d", i, bus.mode, e.mode); end
            $display("[TB] blink period %0d: duty=%0d", i, bus.duty);
        end
    endtask

    task automatic test_cmd_during_descent();
        exp_t e;
        int   d[6] = '{0, 30, 60, 90, 100, 70};
        int   bd0;
        send(2'd3, 8'd30);
        for (int i = 0; i < 6; i++) push(d[i], 3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            pe(20);
            e = exp_q.pop_front();
            n_tests++; if (bus.duty !== e.duty) begin n_fail++; $display("FAIL desc_ramp[%0d]: got %0d want %0d", i, bus.duty, e.duty); end
        end
        bd0 = bd_cnt;
        send(2'd0, 8'd0);
        repeat (3) tick();
        n_tests++; if (bus.duty !== 16'd70) begin n_fail++; $display("FAIL desc_hold: got %0d want 70", bus.duty); end
        n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL desc_ready: got %b want 0", bus.cmd_ready); end
        push(0, 0, 1'b0);
        pe(6);
        e = exp_q.pop_front();
        n_tests++; if (bus.duty !== e.duty) begin n_fail++; $display("FAIL desc_off_duty: got %0d want %0d", bus.duty, e.duty); end
        n_tests++; if (bus.mode !== e.mode) begin n_fail++; $display("FAIL desc_off_mode: got %0d want %0d", bus.mode, e.mode); end
        repeat (2) tick();
        n_tests++; if (bd_cnt != bd0) begin n_fail++; $display("FAIL desc_no_bdone: got %0d pulses want 0", bd_cnt - bd0); end
        $display("[TB] descent: OFF applied, duty=%0d", bus.duty);
    endtask

    task automatic test_collision();
        exp_t e;
        bus.cmd_valid  = 1'b1;
        bus.cmd_mode   = 2'd1;
        bus.cmd_step   = 8'd0;
        bus.period_end = 1'b1;
        tick();
        bus.period_end = 1'b0;
        bus.cmd_mode   = 2'd2;
        n_tests++; if (bus.duty !== 16'd0) begin n_fail++; $display("FAIL coll_duty: got %0d want 0", bus.duty); end
        n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL coll_ready: got %b want 0", bus.cmd_ready); end
        repeat (4) tick();
        n_tests++; if (bus.mode !== 2'd0) begin n_fail++; $display("FAIL coll_mode_wait: got %0d want 0", bus.mode); end
        push(100, 1, 1'b0);
        pe(6);
        bus.cmd_valid = 1'b0;
        e = exp_q.pop_front();
        n_tests++; if (bus.duty !== e.duty) begin n_fail++; $display("FAIL coll_apply_duty: got %0d want %0d", bus.duty, e.duty); end
        n_tests++; if (bus.mode !== e.mode) begin n_fail++; $display("FAIL coll_apply_mode: got %0d want %0d", bus.mode, e.mode); end
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready_back: got %b want 1", bus.cmd_ready); end
        $display("[TB] collision: applied mode=%0d duty=%0d", bus.mode, bus.duty);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        send(2'd2, 8'd0);
        push(100, 2, 1'b0);
        pe(5);
        e = exp_q.pop_front();
        n_tests++; if (bus.duty !== e.duty) begin n_fail++; $display("FAIL rmid_blink: got %0d want %0d", bus.duty, e.duty); end
        pe(5);
        send(2'd1, 8'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_tests++; if (bus.duty !== 16'd0) begin n_fail++; $display("FAIL rmid_duty: got %0d want 0", bus.duty); end
        n_tests++; if (bus.mode !== 2'd0) begin n_fail++; $display("FAIL rmid_mode: got %0d want 0", bus.mode); end
        n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", bus.cmd_ready); end
        tick();
        rst = 1'b1;
        push(0, 0, 1'b0);
        pe(5);
        e = exp_q.pop_front();
        n_tests++; if (bus.duty !== e.duty) begin n_fail++; $display("FAIL rmid_discard_duty: got %0d want %0d", bus.duty, e.duty); end
        n_tests++; if (bus.mode !== e.mode) begin n_fail++; $display("FAIL rmid_discard_mode: got %0d want %0d", bus.mode, e.mode); end
        $display("[TB] mid reset: duty=%0d mode=%0d", bus.duty, bus.mode);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_mode   = 2'd0;
        bus.cmd_step   = 8'd0;
        bus.period_end = 1'b0;
        test_reset();
        test_on();
        test_breath();
        test_step_zero();
        test_blink();
        test_cmd_during_descent();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
